pull_responder_fifo: RTL and testbench
======================================

Name: pull_responder_fifo

Overview:
- Responder (producer-side) end of the dataflow req/ack pull handshake: buffers words written by local logic and serves them to one or more requesters (operator req_l ports, consumers).
- Sits wherever a graph input is fed from a synthesizable source instead of the bench producer.
- Supports fanout: a word is served only when every attached requester asserts req, and all of them see the same ack pulse and data.

Parameters:
- data_width, 32, width of each data word.
- depth, 4, number of FIFO entries; power of two, at least 2.
- output_size, 1, number of requesters sharing this responder.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the clock edge).
- wr_en  in  1  push request from local logic.
- wr_data  in  data_width  word to push.
- full  out  1  FIFO holds depth words; combinational from count.
- overflow  out  1  sticky; set when wr_en is asserted while full.
- req  in  output_size  pull requests, one bit per requester.
- ack  out  1  one-cycle response pulse, shared by all requesters.
- dout  out  data_width  served word; valid in the ack cycle and held until the next ack.
- level  out  $clog2(depth)+1  current occupancy.
- served  out  32  count of acks issued.

Behaviour:
- Reset (rst=0 at a clock edge):
  - ack=0, dout=0, level=0, overflow=0, served=0.
  - Read and write pointers go to 0.
  - FIFO contents are not cleared.
  - A reset mid-transfer discards all buffered words and any pending pull.
- Write:
  - On an edge with wr_en=1 and full=0, wr_data is stored at wr_ptr, and wr_ptr increments modulo depth.
  - With wr_en=1 and full=1, the word is dropped, overflow is set to 1 and held until reset, and the pointers are unchanged.
- Serve condition, evaluated on the registered state at each edge: (&req) & ~ack & (level != 0).
  - When true, on that edge: ack<=1, dout<=mem[rd_ptr], rd_ptr increments modulo depth, served increments.
  - Otherwise ack<=0 and dout holds its value.
- Ack rules:
  - ack is never high for two consecutive cycles; at most one word is served every two cycles.
  - If req holds high continuously, acks alternate every other cycle.
- Partial fanout: if any req bit is low, nothing is served. Data is never delivered to a subset of requesters.
- Latency:
  - A word written at edge N into an empty FIFO, with &req already high, gives ack=1 and dout=word during the cycle after edge N+1.
  - There is no write-to-read bypass.
- Simultaneous write and serve:
  - Both occur on the same edge and level is unchanged.
  - full is evaluated before the pop, so a write while full is still rejected even if a serve happens that edge.
- Pointer wrap-around: pointers are $clog2(depth) bits wide; level disambiguates full from empty.
- served wraps modulo 2^32.
- req is sampled only at clock edges. Requesters must drop req on seeing ack; a req still high after ack is treated as a new request two cycles later.

Decomposition:
- Shared package:
  - ACK_PULSE_CYCLES = 1 constant.
  - Occupancy width function $clog2(depth)+1, also used by other buffered nodes.
- One natural sub-module, sync_fifo_core: storage, pointers, level and full, with push/pop inputs.
- The responder wrapper holds the serve condition, ack/dout registers, overflow and served.

Test Plan:
- Reset then idle:
  - Stimulus: rst=0 for 2 cycles, then rst=1, req=1, no writes.
  - Required: ack stays 0, dout=0, level=0, served=0 for 20 cycles.
- Single word:
  - Stimulus: write 0x2A at edge N with req=1.
  - Required: ack=1 and dout=0x2A in the cycle after edge N+1, then ack=0; level goes 1 then 0; served=1.
- Fanout gating (output_size=3, FIFO holds 7):
  - Stimulus: req=3'b011 for 5 cycles, then 3'b111.
  - Required: no ack while req=3'b011; one ack with dout=7 after req=3'b111.
- Full and overflow (depth=4):
  - Stimulus: write 1..5 back-to-back with req=0.
  - Required: full=1 after the 4th write; overflow=1; level=4.
  - Then req=1: acks deliver 1,2,3,4 on alternate cycles; 5 is never seen.
- Simultaneous push and pop:
  - Stimulus: level=2 and a serve due; write 9 on the same edge.
  - Required: level stays 2; 9 is served after the two older words.
- Reset mid-stream:
  - Stimulus: 3 words buffered, assert rst=0 for one edge.
  - Required: level=0, ack=0, served=0 next cycle; old words are never served.

Source files
------------

// File: rtl/pull_responder_fifo_pkg.sv
// Shared constants and helpers for buffered dataflow nodes.
package pull_responder_fifo_pkg;

  localparam int unsigned ACK_PULSE_CYCLES = 1;

  // Occupancy counters need one extra bit so a full FIFO is distinct from an empty one.
  function automatic int unsigned occ_width(input int unsigned entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Synchronous FIFO storage with push/pop, wrapping pointers and an occupancy count.
module sync_fifo_core
  import pull_responder_fifo_pkg::*;
#(
  parameter int unsigned data_width = 32,
  parameter int unsigned depth      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [data_width-1:0]        push_data,
  input  logic                         pop,
  output logic [data_width-1:0]        pop_data,
  output logic [occ_width(depth)-1:0]  level,
  output logic                         full
);

  localparam int unsigned PtrW = $clog2(depth);
  localparam int unsigned LvlW = occ_width(depth);

  logic [data_width-1:0] mem [depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [LvlW-1:0]       level_q, level_d;
  logic                  push_ok, pop_ok;

  // Full is taken from the pre-pop count, so a write while full is dropped even on a pop edge.
  assign full     = (level_q == LvlW'(depth));
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & (level_q != '0);
  assign pop_data = mem[rd_ptr_q];
  assign level    = level_q;

  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + LvlW'(1);
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - LvlW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst && push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pull_responder_fifo.sv
// Responder end of the req/ack pull handshake: buffers local writes and serves them to all
// attached requesters at once with a shared one-cycle ack.
module pull_responder_fifo
  import pull_responder_fifo_pkg::*;
#(
  parameter int unsigned data_width  = 32,
  parameter int unsigned depth       = 4,
  parameter int unsigned output_size = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [data_width-1:0]        wr_data,
  output logic                         full,
  output logic                         overflow,
  input  logic [output_size-1:0]       req,
  output logic                         ack,
  output logic [data_width-1:0]        dout,
  output logic [occ_width(depth)-1:0]  level,
  output logic [31:0]                  served
);

  logic                  ack_q;
  logic [data_width-1:0] dout_q;
  logic                  overflow_q;
  logic [31:0]           served_q;
  logic                  serve;
  logic [data_width-1:0] head_data;

  sync_fifo_core #(
    .data_width (data_width),
    .depth      (depth)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (serve),
    .pop_data  (head_data),
    .level     (level),
    .full      (full)
  );

  // Every requester must ask; the ~ack term forces a gap cycle between consecutive serves.
  assign serve = (&req) & ~ack_q & (level != '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q      <= 1'b0;
      dout_q     <= '0;
      overflow_q <= 1'b0;
      served_q   <= '0;
    end else begin
      ack_q <= serve;
      if (serve) begin
        dout_q   <= head_data;
        served_q <= served_q + 32'd1;
      end
      if (wr_en && full) overflow_q <= 1'b1;
    end
  end

  assign ack      = ack_q;
  assign dout     = dout_q;
  assign overflow = overflow_q;
  assign served   = served_q;

endmodule

// File: tb/tb_pull_responder_fifo.sv
// Directed-vector bench for pull_responder_fifo with three requesters and a 4-deep FIFO.
module tb_pull_responder_fifo;

  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREQ = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          full;
  logic          overflow;
  logic [NREQ-1:0] req;
  logic          ack;
  logic [DW-1:0] dout;
  logic [2:0]    level;
  logic [31:0]   served;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [2:0]  req;
    logic        e_ack;
    logic [31:0] e_dout;
    logic [2:0]  e_level;
    logic        e_full;
    logic        e_ovf;
    logic [31:0] e_served;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  pull_responder_fifo #(
    .data_width  (DW),
    .depth       (DEPTH),
    .output_size (NREQ)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .overflow (overflow),
    .req      (req),
    .ack      (ack),
    .dout     (dout),
    .level    (level),
    .served   (served)
  );

  // Drive inputs, take one edge, then sample 1 time unit after it.
  task automatic step(input logic r, input logic w, input logic [31:0] d, input logic [2:0] q);
    rst = r; wr_en = w; wr_data = d; req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic e_ack, input logic [31:0] e_dout,
                       input logic [2:0] e_level, input logic e_full, input logic e_ovf,
                       input logic [31:0] e_served);
    n_vec++;
    if (ack !== e_ack || dout !== e_dout || level !== e_level || full !== e_full ||
        overflow !== e_ovf || served !== e_served) begin
      n_bad++;
      $display("FAIL %s: got ack=%0b dout=%0h level=%0d full=%0b ovf=%0b served=%0d; want ack=%0b dout=%0h level=%0d full=%0b ovf=%0b served=%0d",
               name, ack, dout, level, full, overflow, served,
               e_ack, e_dout, e_level, e_full, e_ovf, e_served);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [31:0] d, input logic [2:0] q,
                     input logic a, input logic [31:0] o, input logic [2:0] l,
                     input logic f, input logic v, input logic [31:0] s);
    vec_t x;
    x.rst = r; x.wr_en = w; x.wr_data = d; x.req = q;
    x.e_ack = a; x.e_dout = o; x.e_level = l; x.e_full = f; x.e_ovf = v; x.e_served = s;
    vecs.push_back(x);
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; req = '0;

    // rst wr data req | ack dout level full ovf served
    // Single word with latency: write at edge N, ack after edge N+1.
    add(1, 1, 32'h2A, 3'b111, 0, 32'h00, 1, 0, 0, 1 - 1);
    add(1, 0, 32'h00, 3'b111, 1, 32'h2A, 0, 0, 0, 1);
    add(1, 0, 32'h00, 3'b000, 0, 32'h2A, 0, 0, 0, 1);
    // Fanout gating: partial req never serves.
    add(1, 1, 32'h07, 3'b011, 0, 32'h2A, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 0, 32'h00, 3'b011, 0, 32'h2A, 1, 0, 0, 1);
    add(1, 0, 32'h00, 3'b111, 1, 32'h07, 0, 0, 0, 2);
    add(1, 0, 32'h00, 3'b000, 0, 32'h07, 0, 0, 0, 2);
    // Fill past capacity with req low.
    add(1, 1, 32'h01, 3'b000, 0, 32'h07, 1, 0, 0, 2);
    add(1, 1, 32'h02, 3'b000, 0, 32'h07, 2, 0, 0, 2);
    add(1, 1, 32'h03, 3'b000, 0, 32'h07, 3, 0, 0, 2);
    add(1, 1, 32'h04, 3'b000, 0, 32'h07, 4, 1, 0, 2);
    add(1, 1, 32'h05, 3'b000, 0, 32'h07, 4, 1, 1, 2);
    // Drain: alternate-cycle acks deliver 1..4; 5 was dropped.
    add(1, 0, 32'h00, 3'b111, 1, 32'h01, 3, 0, 1, 3);
    add(1, 0, 32'h00, 3'b111, 0, 32'h01, 3, 0, 1, 3);
    add(1, 0, 32'h00, 3'b111, 1, 32'h02, 2, 0, 1, 4);
    add(1, 0, 32'h00, 3'b111, 0, 32'h02, 2, 0, 1, 4);
    add(1, 0, 32'h00, 3'b111, 1, 32'h03, 1, 0, 1, 5);
    add(1, 0, 32'h00, 3'b111, 0, 32'h03, 1, 0, 1, 5);
    add(1, 0, 32'h00, 3'b111, 1, 32'h04, 0, 0, 1, 6);
    add(1, 0, 32'h00, 3'b111, 0, 32'h04, 0, 0, 1, 6);
    add(1, 0, 32'h00, 3'b111, 0, 32'h04, 0, 0, 1, 6);

    // Reset held two edges, then 20 idle cycles with req high.
    step(0, 0, '0, 3'b000);
    check("reset_0", 0, 0, 0, 0, 0, 0);
    step(0, 0, '0, 3'b000);
    check("reset_1", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, '0, 3'b111);
      check($sformatf("idle_%0d", i), 0, 0, 0, 0, 0, 0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr_en, vecs[i].wr_data, vecs[i].req);
      check($sformatf("vec_%0d", i), vecs[i].e_ack, vecs[i].e_dout, vecs[i].e_level,
            vecs[i].e_full, vecs[i].e_ovf, vecs[i].e_served);
    end

    // Simultaneous push and pop at level 2: level holds, 9 follows the older words.
    step(1, 1, 32'h11, 3'b000); check("pp_w1", 0, 32'h04, 1, 0, 1, 6);
    step(1, 1, 32'h22, 3'b000); check("pp_w2", 0, 32'h04, 2, 0, 1, 6);
    step(1, 1, 32'h09, 3'b111); check("pp_both", 1, 32'h11, 2, 0, 1, 7);
    step(1, 0, 32'h00, 3'b111); check("pp_gap1", 0, 32'h11, 2, 0, 1, 7);
    step(1, 0, 32'h00, 3'b111); check("pp_s2", 1, 32'h22, 1, 0, 1, 8);
    step(1, 0, 32'h00, 3'b111); check("pp_gap2", 0, 32'h22, 1, 0, 1, 8);
    step(1, 0, 32'h00, 3'b111); check("pp_s9", 1, 32'h09, 0, 0, 1, 9);
    step(1, 0, 32'h00, 3'b000); check("pp_idle", 0, 32'h09, 0, 0, 1, 9);

    // Write while full on a serve edge is still rejected.
    step(1, 1, 32'h31, 3'b000); check("fp_w1", 0, 32'h09, 1, 0, 1, 9);
    step(1, 1, 32'h32, 3'b000); check("fp_w2", 0, 32'h09, 2, 0, 1, 9);
    step(1, 1, 32'h33, 3'b000); check("fp_w3", 0, 32'h09, 3, 0, 1, 9);
    step(1, 1, 32'h34, 3'b000); check("fp_w4", 0, 32'h09, 4, 1, 1, 9);
    step(1, 1, 32'hAA, 3'b111); check("fp_both", 1, 32'h31, 3, 0, 1, 10);

    // Reset mid-stream with three words buffered: nothing old is ever served.
    step(0, 0, 32'h00, 3'b111); check("rm_rst", 0, 32'h00, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 32'h00, 3'b111);
      check($sformatf("rm_idle_%0d", i), 0, 32'h00, 0, 0, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
